// File: rtl/card_hand_scanner_if.sv
// Host-side configuration bus for the card hand scanner: shadow slot writes
// plus the selection highlight that is sampled into the shadow bank every cycle.
interface card_hand_scanner_if;
   logic       wr_en;
   logic [2:0] wr_slot;
   logic       wr_present;
   logic [2:0] wr_type;
   logic [3:0] wr_num;
   logic       sel_en;
   logic [2:0] sel_slot;

   modport master (
      output wr_en, wr_slot, wr_present, wr_type, wr_num, sel_en, sel_slot
   );

   modport slave (
      input  wr_en, wr_slot, wr_present, wr_type, wr_num, sel_en, sel_slot
   );
endinterface

// File: rtl/card_hand_scanner.sv
// Maps each scanned pixel onto a hand of card slots and drives the card renderer.
// Slot contents are double-buffered so the displayed hand only changes at frame_start.
module card_hand_scanner #(
   parameter int         NUM_SLOTS = 5,
   parameter logic [9:0] HAND_X0   = 10'd40,
   parameter logic [9:0] HAND_Y0   = 10'd400,
   parameter logic [9:0] PITCH     = 10'd64,
   parameter logic [6:0] CARD_W    = 7'd54,
   parameter logic [6:0] CARD_H    = 7'd68,
   parameter logic [9:0] RAISE     = 10'd12
) (
   input  logic                 vga_clk,
   input  logic                 reset,
   input  logic [9:0]           pixel_x,
   input  logic [9:0]           pixel_y,
   input  logic                 frame_start,
   card_hand_scanner_if.slave   wr_bus,
   output logic [6:0]           x_pos,
   output logic [6:0]           y_pos,
   output logic [2:0]           card_type,
   output logic [3:0]           card_num,
   output logic                 hit_d2,
   output logic [2:0]           slot_d2
);

   typedef struct packed {
      logic       present;
      logic [2:0] ctype;
      logic [3:0] cnum;
   } slot_t;

   typedef struct packed {
      logic       en;
      logic [2:0] slot;
   } sel_t;

   slot_t shadow_q [NUM_SLOTS];
   slot_t active_q [NUM_SLOTS];
   sel_t  shadow_sel_q;
   sel_t  active_sel_q;

   // ---------------------------------------------------------------
   // Slot banks
   // ---------------------------------------------------------------
   // NOTE: the banks are a handful of flops, not RAM, so they take the
   // synchronous reset like any other state; a reset mid-frame must blank
   // the hand until software repopulates it.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         shadow_sel_q <= '0;
         active_sel_q <= '0;
      end else begin
         // NOTE: non-blocking assignments mean the commit reads the shadow
         // as it was before any write landing on this same edge.
         if (frame_start) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
               active_q[i] <= shadow_q[i];
            end
            active_sel_q <= shadow_sel_q;
         end
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (wr_bus.wr_en && (wr_bus.wr_slot == 3'(i))) begin
               shadow_q[i] <= '{present: wr_bus.wr_present,
                                ctype:   wr_bus.wr_type,
                                cnum:    wr_bus.wr_num};
            end
         end
         shadow_sel_q <= '{en: wr_bus.sel_en, slot: wr_bus.sel_slot};
      end
   end

   // ---------------------------------------------------------------
   // Per-slot geometry: 11-bit differences, sign bit set means "left of"
   // or "above" the card, which is never a hit.
   // ---------------------------------------------------------------
   logic [NUM_SLOTS-1:0] slot_hit;
   logic [6:0]           slot_dx [NUM_SLOTS];
   logic [6:0]           slot_dy [NUM_SLOTS];

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      localparam logic [10:0] SLOT_X0 = {1'b0, HAND_X0} + (11'(g) * {1'b0, PITCH});

      logic        raised;
      logic [10:0] top;
      logic [10:0] dx;
      logic [10:0] dy;

      assign raised = active_sel_q.en && (active_sel_q.slot == 3'(g));
      assign top    = {1'b0, HAND_Y0} - (raised ? {1'b0, RAISE} : 11'd0);
      assign dx     = {1'b0, pixel_x} - SLOT_X0;
      assign dy     = {1'b0, pixel_y} - top;

      assign slot_hit[g] = active_q[g].present
                        && !dx[10] && (dx < {4'b0, CARD_W})
                        && !dy[10] && (dy < {4'b0, CARD_H});
      assign slot_dx[g]  = dx[6:0];
      assign slot_dy[g]  = dy[6:0];
   end

   // ---------------------------------------------------------------
   // Slot select: slots never overlap, so at most one bit of slot_hit is set.
   // ---------------------------------------------------------------
   logic [6:0] x_pos_d;
   logic [6:0] y_pos_d;
   logic [2:0] card_type_d;
   logic [3:0] card_num_d;
   logic       hit_d;
   logic [2:0] slot_d;

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value held and infer a latch.
   always_comb begin
      x_pos_d     = '0;
      y_pos_d     = '0;
      card_type_d = '0;
      card_num_d  = '0;
      hit_d       = 1'b0;
      slot_d      = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (slot_hit[i]) begin
            x_pos_d     = slot_dx[i];
            y_pos_d     = slot_dy[i];
            card_type_d = active_q[i].ctype;
            card_num_d  = active_q[i].cnum;
            hit_d       = 1'b1;
            slot_d      = 3'(i);
         end
      end
   end

   // ---------------------------------------------------------------
   // Stage 0 and the hit delay pipe matching the renderer's ROM latency.
   // ---------------------------------------------------------------
   logic       hit_d0;
   logic [2:0] slot_d0;
   logic       hit_d1;
   logic [2:0] slot_d1;

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         x_pos     <= '0;
         y_pos     <= '0;
         card_type <= '0;
         card_num  <= '0;
         hit_d0    <= 1'b0;
         slot_d0   <= '0;
         hit_d1    <= 1'b0;
         slot_d1   <= '0;
         hit_d2    <= 1'b0;
         slot_d2   <= '0;
      end else begin
         x_pos     <= x_pos_d;
         y_pos     <= y_pos_d;
         card_type <= card_type_d;
         card_num  <= card_num_d;
         hit_d0    <= hit_d;
         slot_d0   <= slot_d;
         hit_d1    <= hit_d0;
         slot_d1   <= slot_d0;
         hit_d2    <= hit_d1;
         slot_d2   <= slot_d1;
      end
   end

endmodule

// File: tb/tb_card_hand_scanner.sv
// Directed bench for card_hand_scanner: stimulus pushes hand-computed expectations
// tagged with the cycle they are due; a negedge monitor pops and compares them.
module tb_card_hand_scanner;

   logic       vga_clk = 1'b0;
   logic       reset;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       frame_start;
   logic [6:0] x_pos;
   logic [6:0] y_pos;
   logic [2:0] card_type;
   logic [3:0] card_num;
   logic       hit_d2;
   logic [2:0] slot_d2;

   card_hand_scanner_if bus ();

   card_hand_scanner dut (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .frame_start (frame_start),
      .wr_bus      (bus.slave),
      .x_pos       (x_pos),
      .y_pos       (y_pos),
      .card_type   (card_type),
      .card_num    (card_num),
      .hit_d2      (hit_d2),
      .slot_d2     (slot_d2)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct {
      int         due;
      logic [6:0] xp;
      logic [6:0] yp;
      logic [2:0] ct;
      logic [3:0] cn;
   } s0_exp_t;

   typedef struct {
      int         due;
      logic       hit;
      logic [2:0] slot;
   } hit_exp_t;

   s0_exp_t  q_s0 [$];
   hit_exp_t q_hit [$];
   s0_exp_t  e0;
   hit_exp_t eh;

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;

   always @(posedge vga_clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Monitor: compare every expectation due at this cycle.
   always @(negedge vga_clk) begin
      while (q_s0.size() > 0 && q_s0[0].due <= cyc) begin
         e0 = q_s0.pop_front();
         check("s0_due", cyc, e0.due);
         check("x_pos", int'(x_pos), int'(e0.xp));
         check("y_pos", int'(y_pos), int'(e0.yp));
         check("card_type", int'(card_type), int'(e0.ct));
         check("card_num", int'(card_num), int'(e0.cn));
      end
      while (q_hit.size() > 0 && q_hit[0].due <= cyc) begin
         eh = q_hit.pop_front();
         check("hit_due", cyc, eh.due);
         check("hit_d2", int'(hit_d2), int'(eh.hit));
         check("slot_d2", int'(slot_d2), int'(eh.slot));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge vga_clk);
      #1;
      reset       = 1'b0;
      frame_start = 1'b0;
      bus.wr_en   = 1'b0;
   endtask

   task automatic px(input int x, input int y, input logic hit, input int xp, input int yp,
                     input int ct, input int cn, input int slot);
      step();
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      q_s0.push_back('{cyc + 1, 7'(xp), 7'(yp), 3'(ct), 4'(cn)});
      q_hit.push_back('{cyc + 3, hit, 3'(slot)});
   endtask

   task automatic px_miss(input int x, input int y);
      px(x, y, 1'b0, 0, 0, 0, 0, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic wr(input int slot, input logic pr, input int ty, input int nu);
      step();
      bus.wr_en      = 1'b1;
      bus.wr_slot    = 3'(slot);
      bus.wr_present = pr;
      bus.wr_type    = 3'(ty);
      bus.wr_num     = 4'(nu);
   endtask

   task automatic fs();
      step();
      frame_start = 1'b1;
   endtask

   task automatic wr_fs(input int slot, input logic pr, input int ty, input int nu);
      wr(slot, pr, ty, nu);
      frame_start = 1'b1;
   endtask

   task automatic sel(input logic en, input int slot);
      step();
      bus.sel_en   = en;
      bus.sel_slot = 3'(slot);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int r;
      reset          = 1'b1;
      frame_start    = 1'b0;
      pixel_x        = '0;
      pixel_y        = '0;
      bus.wr_en      = 1'b0;
      bus.wr_slot    = '0;
      bus.wr_present = 1'b0;
      bus.wr_type    = '0;
      bus.wr_num     = '0;
      bus.sel_en     = 1'b0;
      bus.sel_slot   = '0;
      repeat (3) @(posedge vga_clk);
      @(negedge vga_clk);
      check("rst_x_pos", int'(x_pos), 0);
      check("rst_y_pos", int'(y_pos), 0);
      check("rst_hit_d2", int'(hit_d2), 0);
      check("rst_slot_d2", int'(slot_d2), 0);

      // Empty hand: a full line through the hand band never hits.
      fs();
      for (int x = 0; x < 640; x++) px_miss(x, 420);

      // Slot 0 corners and just-outside neighbours.
      wr(0, 1'b1, 2, 7);
      fs();
      px(40, 400, 1'b1, 0, 0, 2, 7, 0);
      px(93, 467, 1'b1, 53, 67, 2, 7, 0);
      px_miss(94, 400);
      px_miss(40, 468);
      px_miss(39, 400);

      // Raised slot 1.
      wr(1, 1'b1, 5, 3);
      sel(1'b1, 1);
      fs();
      px(104, 388, 1'b1, 0, 0, 5, 3, 1);
      px(157, 455, 1'b1, 53, 67, 5, 3, 1);
      px_miss(104, 467);
      px_miss(40, 388);
      px_miss(40, 399);
      px(40, 400, 1'b1, 0, 0, 2, 7, 0);

      // Mid-frame write stays invisible until the next commit.
      wr(2, 1'b1, 3, 9);
      px_miss(168, 400);
      px_miss(200, 430);
      fs();
      px(168, 400, 1'b1, 0, 0, 3, 9, 2);
      px(200, 430, 1'b1, 32, 30, 3, 9, 2);

      // Write coincident with commit lands one frame late.
      wr_fs(3, 1'b1, 6, 12);
      px_miss(232, 400);
      fs();
      px(232, 400, 1'b1, 0, 0, 6, 12, 3);

      // Out-of-range write slot and out-of-range selection.
      wr(6, 1'b1, 7, 15);
      sel(1'b1, 6);
      fs();
      px_miss(424, 400);
      px_miss(104, 388);
      px(40, 400, 1'b1, 0, 0, 2, 7, 0);
      px(104, 400, 1'b1, 0, 0, 5, 3, 1);

      // Reset while the pixel sits on a present card.
      idle(3);
      step();
      reset = 1'b1;
      r = cyc;
      q_hit.push_back('{r, 1'b1, 3'd1});
      for (int k = 1; k <= 4; k++) begin
         q_s0.push_back('{r + k, 7'd0, 7'd0, 3'd0, 4'd0});
         q_hit.push_back('{r + k, 1'b0, 3'd0});
      end
      idle(4);
      fs();
      px_miss(104, 400);
      px_miss(40, 400);
      idle(5);

      check("drain_s0", q_s0.size(), 0);
      check("drain_hit", q_hit.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/card_hand_scanner.md
Name: card_hand_scanner

Overview:
- Stage directly upstream of the card renderer in the VGA path.
- Holds the displayed hand of up to NUM_SLOTS cards in double-buffered slot registers.
- Per pixel, it maps screen coordinates to a slot and to card-local coordinates, and drives the renderer's x_pos/y_pos/card_type/card_num.
- It also emits a hit flag delay-matched to the renderer's 2-cycle ROM latency, so the compositor knows which pixels carry card colour.

Parameters:
- NUM_SLOTS, 5, number of card slots in the hand (1..8).
- HAND_X0, 10'd40, screen x of slot 0 left edge.
- HAND_Y0, 10'd400, screen y of unraised card top edge.
- PITCH, 10'd64, x distance between slot left edges; must be >= CARD_W, so slots never overlap.
- CARD_W, 7'd54, card width in pixels.
- CARD_H, 7'd68, card height in pixels.
- RAISE, 10'd12, upward offset of the selected card.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- pixel_x  in  10  current scan x.
- pixel_y  in  10  current scan y.
- frame_start  in  1  one-cycle pulse at start of vertical blank; commits shadow to active.
- wr_en  in  1  write one shadow slot this cycle.
- wr_slot  in  3  shadow slot index.
- wr_present  in  1  slot holds a card.
- wr_type  in  3  card_type for slot.
- wr_num  in  4  card_num for slot.
- sel_en  in  1  selection highlight enable (shadow).
- sel_slot  in  3  selected slot (shadow); sampled every cycle into shadow.
- x_pos  out  7  card-local x to renderer.
- y_pos  out  7  card-local y to renderer.
- card_type  out  3  to renderer.
- card_num  out  4  to renderer.
- hit_d2  out  1  pixel is inside a present card; aligned with renderer out_data.
- slot_d2  out  3  slot index of that hit; aligned with hit_d2.

Behaviour:
- Shadow bank: per slot {present, type, num}.
  - wr_en with wr_slot < NUM_SLOTS writes the slot on the clock edge.
  - wr_slot >= NUM_SLOTS is ignored.
  - sel_en/sel_slot are registered into shadow every cycle.
- Active bank:
  - Copied from shadow on the edge where frame_start=1.
  - Never changes mid-frame.
  - When wr_en and frame_start occur in the same cycle, the active bank receives the pre-write shadow value; the write lands in shadow only and commits at the next frame_start.
- Slot geometry:
  - Slot i spans x in [HAND_X0+i*PITCH, HAND_X0+i*PITCH+CARD_W-1].
  - top_i = HAND_Y0 - RAISE if (active sel_en && active sel_slot==i), else HAND_Y0. Spans y in [top_i, top_i+CARD_H-1].
  - All compares are on 10-bit unsigned values with a 1-bit extension. Negative differences are not hits; no wrap-around hits.
  - Selection with sel_slot >= NUM_SLOTS raises nothing.
- Stage 0 (registered, 1 cycle after pixel_x/pixel_y):
  - On a hit in present slot i: x_pos = pixel_x-slot_x0_i (0..CARD_W-1), y_pos = pixel_y-top_i (0..CARD_H-1), card_type/card_num = active slot i values, internal hit_d0=1, slot_d0=i.
  - Otherwise: x_pos=0, y_pos=0, card_type=0, card_num=0, hit_d0=0, slot_d0=0.
  - Slots never overlap; at most one slot matches.
- Delay pipe: hit_d0/slot_d0 pass through 2 registers to give hit_d2/slot_d2. Total latency from pixel_x/pixel_y to hit_d2 is 3 cycles, equal to the latency to renderer out_data.
- Reset (synchronous):
  - All outputs and the pipe clear to 0.
  - Shadow and active banks clear to present=0, type=0, num=0, sel_en=0, sel_slot=0.
  - Reset asserted mid-frame: hit_d2 reads 0 from the cycle after the reset edge. No hit is produced until a frame_start after reset has committed a populated shadow bank.
- Reset has priority over frame_start and wr_en in the same cycle.

Test Plan:
- Reset, then frame_start, then scan full line y=420 → hit_d2 stays 0, x_pos=y_pos=0 throughout.
- Write slot0 {present,type=2,num=7}, frame_start; drive (40,400) → 1 cycle later x_pos=0,y_pos=0,card_type=2,card_num=7; 3 cycles later hit_d2=1, slot_d2=0. Drive (93,467) → x_pos=53, y_pos=67, hit. Drive (94,400) and (40,468) → no hit.
- Slot1 present, sel_en=1, sel_slot=1, commit → (104,388) hits with y_pos=0. (104,467) no hit. Slot0 at (40,388) no hit.
- Write slot2 mid-frame without frame_start → pixels in slot2 region still miss until next frame_start, then hit with new type/num.
- wr_en (slot3) coincident with frame_start → slot3 absent this frame, present after the following frame_start. wr_slot=6 write with NUM_SLOTS=5 → no state change.
- Reset pulsed mid-line while over a present card → hit_d2=0 from next cycle, and stays 0 after the next frame_start with no writes.
